// File: rtl/qdec_mvd_egk_dec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_cabac_package
// Shared CABAC sub-FSM definitions: the MVD/EGk decoder state encoding, the
// accumulator phase encoding, the context-index constants that the parent PU
// FSM drives onto the MVD decoder's address inputs, and small state helpers.
// -----------------------------------------------------------------------------
package qdec_cabac_package;

    typedef enum logic [2:0] {
        IDLE,
        GT0,
        GT1,
        PREFIX,
        SUFFIX,
        SIGN,
        DONE
    } t_state_mvd_egk;

    typedef enum logic [1:0] {
        EGK_NONE,
        EGK_PREFIX,
        EGK_SUFFIX
    } t_egk_phase;

    // Context indices of abs_mvd_greater0_flag / abs_mvd_greater1_flag.
    localparam int unsigned CTXIDX_ABS_MVD_GT0_FLAG = 42;
    localparam int unsigned CTXIDX_ABS_MVD_GT1_FLAG = 43;

    // Internal EGk accumulator width; the result is truncated to MVD_W.
    localparam int EGK_ACC_W = 32;

    // States that consume one bin from the arithmetic engine.
    function automatic logic needs_bin(t_state_mvd_egk s);
        return s inside {GT0, GT1, PREFIX, SUFFIX, SIGN};
    endfunction

    // States whose bins are bypass-coded.
    function automatic logic is_bypass(t_state_mvd_egk s);
        return s inside {PREFIX, SUFFIX, SIGN};
    endfunction

endpackage

// File: rtl/qdec_mvd_egk_dec_egk_accum.sv
// -----------------------------------------------------------------------------
// qdec_egk_accum
// Exp-Golomb (order k) prefix/suffix accumulator for abs_mvd_minus2.
// Prefix: each 1 adds 1<<k and bumps k; a 0 arms a k-bit MSB-first suffix.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           clear accumulator and load k0 (new component)
//   k0              initial EGk order
//   bin, bin_vld    accepted bypass bin and its strobe
//   phase           which part of the codeword the bin belongs to
//   value           accumulated abs_mvd_minus2 (registered)
//   suffix_done     this bin completes the codeword (combinational)
//   overflow        this bin is the MAX_PREFIX-th prefix one (combinational)
// -----------------------------------------------------------------------------
module qdec_egk_accum
    import qdec_cabac_package::*;
#(
    parameter int MAX_PREFIX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [5:0]           k0,
    input  logic                 bin,
    input  logic                 bin_vld,
    input  t_egk_phase           phase,
    output logic [EGK_ACC_W-1:0] value,
    output logic                 suffix_done,
    output logic                 overflow
);

    logic [5:0]           k;
    logic [5:0]           ones;
    logic [5:0]           cnt;
    logic [EGK_ACC_W-1:0] acc;
    logic [EGK_ACC_W-1:0] suf;
    logic [EGK_ACC_W-1:0] suf_nxt;
    logic                 prefix_bin;
    logic                 suffix_bin;

    assign prefix_bin = bin_vld && (phase == EGK_PREFIX);
    assign suffix_bin = bin_vld && (phase == EGK_SUFFIX);
    assign suf_nxt    = {suf[EGK_ACC_W-2:0], bin};
    assign value      = acc;

    assign overflow    = prefix_bin && bin && (ones == 6'(MAX_PREFIX - 1));
    // A terminating prefix 0 with k==0 leaves no suffix bits to read.
    assign suffix_done = (suffix_bin && (cnt == 6'd1)) ||
                         (prefix_bin && !bin && (k == 6'd0));

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            k    <= '0;
            ones <= '0;
            cnt  <= '0;
            acc  <= '0;
            suf  <= '0;
        end else if (start) begin
            k    <= k0;
            ones <= '0;
            cnt  <= '0;
            acc  <= '0;
            suf  <= '0;
        end else if (prefix_bin) begin
            if (bin) begin
                acc  <= acc + (EGK_ACC_W'(1) << k);
                k    <= k + 6'd1;
                ones <= ones + 6'd1;
            end else begin
                cnt <= k;
                suf <= '0;
            end
        end else if (suffix_bin) begin
            suf <= suf_nxt;
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
                acc <= acc + suf_nxt;
            end
        end
    end

endmodule

// File: rtl/qdec_mvd_egk_dec.sv
// -----------------------------------------------------------------------------
// qdec_mvd_egk_dec
// MVD decoder sub-FSM: sequences greater0/greater1 context bins, the EGk
// remainder and the sign bin for NUM_COMP components, then returns signed
// MVDs with a one-cycle valid pulse.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mvd_start                   start pulse (honoured in IDLE only)
//   ctx_gt0_addr, ctx_gt1_addr  context addresses for greater0/greater1
//   ctx_addr, ctx_addr_vld      bin request address and strobe
//   dec_run                     ctx_addr_vld delayed one cycle
//   ep_mode                     1 = bypass bin for the current request
//   dec_rdy                     engine accepts requests
//   bin, bin_vld                decoded bin and strobe
//   mvd_out, mvd_out_vld        packed signed MVDs (comp 0 in LSBs), pulse
//   mvd_err                     prefix overflow, pulses with mvd_out_vld
// -----------------------------------------------------------------------------
module qdec_mvd_egk_dec
    import qdec_cabac_package::*;
#(
    parameter int NUM_COMP   = 2,
    parameter int EGK_ORDER  = 1,
    parameter int MAX_PREFIX = 16,
    parameter int MVD_W      = 16,
    parameter int CTX_ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mvd_start,
    input  logic [CTX_ADDR_W-1:0]     ctx_gt0_addr,
    input  logic [CTX_ADDR_W-1:0]     ctx_gt1_addr,
    output logic [CTX_ADDR_W-1:0]     ctx_addr,
    output logic                      ctx_addr_vld,
    output logic                      dec_run,
    output logic                      ep_mode,
    input  logic                      dec_rdy,
    input  logic                      bin,
    input  logic                      bin_vld,
    output logic [NUM_COMP*MVD_W-1:0] mvd_out,
    output logic                      mvd_out_vld,
    output logic                      mvd_err
);

    localparam int CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    t_state_mvd_egk       state, nxt_state;
    logic [CW-1:0]        comp_idx, nxt_comp;
    logic [NUM_COMP-1:0]  gt0, gt1, nxt_gt0, nxt_gt1;
    logic                 pending, pending_hold, take, issue;
    logic                 acc_start, err_r;
    logic [CW:0]          sel;
    logic [MVD_W-1:0]     res [NUM_COMP];
    logic [MVD_W-1:0]     mag;
    logic [EGK_ACC_W-1:0] acc_value;
    logic                 suffix_done, overflow;
    t_egk_phase           phase;

    // Lowest set index of mask at or above 'from'; MSB flags a hit.
    function automatic logic [CW:0] first_set(logic [NUM_COMP-1:0] mask, int from);
        logic [CW:0] r;
        r = '0;
        for (int i = NUM_COMP - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    // A bin only counts when it answers our single outstanding request.
    assign take         = bin_vld && pending;
    assign pending_hold = pending && !take;
    assign issue        = needs_bin(nxt_state) && !pending_hold && dec_rdy;

    assign phase = (state == PREFIX) ? EGK_PREFIX :
                   (state == SUFFIX) ? EGK_SUFFIX : EGK_NONE;
    assign mag   = gt1[comp_idx] ? MVD_W'(acc_value + EGK_ACC_W'(2)) : MVD_W'(1);

    qdec_egk_accum #(
        .MAX_PREFIX (MAX_PREFIX)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .start       (acc_start),
        .k0          (6'(EGK_ORDER)),
        .bin         (bin),
        .bin_vld     (take),
        .phase       (phase),
        .value       (acc_value),
        .suffix_done (suffix_done),
        .overflow    (overflow)
    );

    // Next-state is combinational so a request can issue on the same edge
    // that consumes the previous bin (bin_vld at t -> ctx_addr_vld at t+1).
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a variable unassigned (no latches).
        nxt_state = state;
        nxt_comp  = comp_idx;
        nxt_gt0   = gt0;
        nxt_gt1   = gt1;
        acc_start = 1'b0;
        sel       = '0;
        case (state)
            IDLE: begin
                if (mvd_start) begin
                    nxt_state = GT0;
                    nxt_comp  = '0;
                    nxt_gt0   = '0;
                    nxt_gt1   = '0;
                end
            end
            GT0: begin
                if (take) begin
                    nxt_gt0[comp_idx] = bin;
                    if (comp_idx == CW'(NUM_COMP - 1)) begin
                        sel       = first_set(nxt_gt0, 0);
                        nxt_comp  = sel[CW-1:0];
                        nxt_state = sel[CW] ? GT1 : DONE;
                    end else begin
                        nxt_comp = comp_idx + 1'b1;
                    end
                end
            end
            GT1: begin
                if (take) begin
                    nxt_gt1[comp_idx] = bin;
                    sel = first_set(gt0, int'(comp_idx) + 1);
                    if (sel[CW]) begin
                        nxt_comp = sel[CW-1:0];
                    end else begin
                        // All greater1 flags known: begin the first nonzero component.
                        sel       = first_set(gt0, 0);
                        nxt_comp  = sel[CW-1:0];
                        acc_start = nxt_gt1[sel[CW-1:0]];
                        nxt_state = nxt_gt1[sel[CW-1:0]] ? PREFIX : SIGN;
                    end
                end
            end
            PREFIX: begin
                if (take) begin
                    if (overflow) begin
                        nxt_state = DONE;
                    end else if (!bin) begin
                        nxt_state = suffix_done ? SIGN : SUFFIX;
                    end
                end
            end
            SUFFIX: begin
                if (take && suffix_done) nxt_state = SIGN;
            end
            SIGN: begin
                if (take) begin
                    sel = first_set(gt0, int'(comp_idx) + 1);
                    if (sel[CW]) begin
                        nxt_comp  = sel[CW-1:0];
                        acc_start = gt1[sel[CW-1:0]];
                        nxt_state = gt1[sel[CW-1:0]] ? PREFIX : SIGN;
                    end else begin
                        nxt_state = DONE;
                    end
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            comp_idx     <= '0;
            gt0          <= '0;
            gt1          <= '0;
            pending      <= 1'b0;
            err_r        <= 1'b0;
            ctx_addr     <= '0;
            ctx_addr_vld <= 1'b0;
            dec_run      <= 1'b0;
            ep_mode      <= 1'b0;
            mvd_out      <= '0;
            mvd_out_vld  <= 1'b0;
            mvd_err      <= 1'b0;
            // NOTE: the per-component result array is a handful of flops, not
            // a RAM, so it is reset with everything else and never leaks stale MVDs.
            for (int i = 0; i < NUM_COMP; i++) res[i] <= '0;
        end else begin
            state        <= nxt_state;
            comp_idx     <= nxt_comp;
            gt0          <= nxt_gt0;
            gt1          <= nxt_gt1;
            pending      <= pending_hold || issue;
            ctx_addr_vld <= issue;
            dec_run      <= ctx_addr_vld;
            mvd_out_vld  <= 1'b0;
            mvd_err      <= 1'b0;

            // Address and mode only change on a new request, so they hold
            // steady until the matching bin returns.
            if (issue) begin
                ctx_addr <= (nxt_state == GT0) ? ctx_gt0_addr :
                            (nxt_state == GT1) ? ctx_gt1_addr : '0;
                ep_mode  <= is_bypass(nxt_state);
            end

            if (state == IDLE && mvd_start) begin
                err_r <= 1'b0;
                for (int i = 0; i < NUM_COMP; i++) res[i] <= '0;
            end

            if (state == SIGN && take) begin
                res[comp_idx] <= bin ? (~mag + 1'b1) : mag;
            end

            // Overflowed component keeps its cleared (zero) result.
            if (state == PREFIX && take && overflow) err_r <= 1'b1;

            if (state == DONE) begin
                mvd_out_vld <= 1'b1;
                mvd_err     <= err_r;
                for (int i = 0; i < NUM_COMP; i++) mvd_out[i*MVD_W +: MVD_W] <= res[i];
            end
        end
    end

endmodule

// File: doc/qdec_mvd_egk_dec.md
# qdec_mvd_egk_dec

Parametrised motion-vector-difference decoder in the CABAC sub-FSM group. It sequences the context-coded greater0/greater1 flags and the bypass-coded EGk remainder and sign for NUM_COMP components. It reconstructs signed MVD values and returns them to the prediction-unit FSM with a valid pulse. It sits between the PU syntax FSM and the shared arithmetic decoding engine, driving the engine's context-address and run handshake.

## Interface
- NUM_COMP, 2: number of MVD components decoded per start (1..4)
- EGK_ORDER, 1: initial Exp-Golomb order k for abs_mvd_minus2
- MAX_PREFIX, 16: maximum prefix ones before the error abort (<=30)
- MVD_W, 16: signed output width per component
- CTX_ADDR_W, 10: context memory address width

- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- mvd_start  in  1  one-cycle start pulse; honoured only in IDLE
- ctx_gt0_addr  in  CTX_ADDR_W  context address for greater0 flags
- ctx_gt1_addr  in  CTX_ADDR_W  context address for greater1 flags
- ctx_addr  out  CTX_ADDR_W  context address of the current bin request
- ctx_addr_vld  out  1  one-cycle bin request strobe
- dec_run  out  1  ctx_addr_vld delayed one cycle
- ep_mode  out  1  1 = bypass bin; valid alongside ctx_addr_vld
- dec_rdy  in  1  engine can accept a request
- bin  in  1  decoded bin value
- bin_vld  in  1  bin strobe
- mvd_out  out  NUM_COMP*MVD_W  signed MVDs; component 0 in the LSBs
- mvd_out_vld  out  1  one-cycle result pulse
- mvd_err  out  1  prefix overflow; coincident with mvd_out_vld

## Operation
- States: IDLE, GT0, GT1, PREFIX, SUFFIX, SIGN, DONE. Component index comp_idx counts 0..NUM_COMP-1.
- GT0: one context bin per component at ctx_gt0_addr. Result stored in gt0[c].
- GT1: one context bin at ctx_gt1_addr, only for components with gt0[c]=1. Skipped entirely if no gt0 is set.
- Per component in ascending order:
  - if gt1[c]=1: PREFIX, then SUFFIX;
  - if gt0[c]=1: SIGN;
  - if gt0[c]=0: skip the component.
- PREFIX (bypass): on bin 1, acc += 1<<k and k++. On bin 0, go to SUFFIX with a count of k bits.
- SUFFIX (bypass): MSB-first k bits, suf = {suf, bin}; acc += suf at the end. k=0 is not possible.
- Magnitude and sign:
  - abs = acc + 2 if gt1, 1 if only gt0, 0 otherwise.
  - mvd = sign ? -abs : abs, truncated to MVD_W.
- Overflow: a prefix count reaching MAX_PREFIX ones triggers an immediate DONE. That component outputs 0, mvd_err=1, and no further bins are requested.
- DONE: pulse mvd_out_vld, then return to IDLE. mvd_out holds its value until the next DONE.
- Request handshake:
  - Exactly one request outstanding at a time.
  - A request issues when the state needs a bin, no request is outstanding, and dec_rdy=1.
  - bin_vld with no request outstanding is ignored.

## Timing
- Reset: all outputs 0, state IDLE, gt0/gt1/acc/k cleared.
- mvd_start at cycle t gives the first ctx_addr_vld at t+1 (if dec_rdy=1).
- bin_vld at cycle t gives the next ctx_addr_vld at t+1 (if dec_rdy=1). The final bin_vld gives mvd_out_vld at t+2.
- ctx_addr and ep_mode are registered and stable from ctx_addr_vld until the matching bin_vld.
- dec_rdy=0 stalls request issue indefinitely; there is no timeout.
- rst mid-decode aborts on the next edge. No mvd_out_vld is emitted and outputs return to reset values.
- mvd_start during a decode is ignored.

## Structure
- Shared package qdec_cabac_package holds:
  - the state enum t_state_mvd_egk;
  - the existing CTXIDX_ABS_MVD_GT0_FLAG/GT1_FLAG constants, which the parent uses to drive the address inputs.
- Sub-module qdec_egk_accum implements prefix/suffix accumulation:
  - inputs: start, k0, bin, bin_vld, phase;
  - outputs: value, suffix_done, overflow.

## Test plan
- NUM_COMP=2, bins gt0=0,0 -> 2 context requests at ctx_gt0_addr, mvd_out=(0,0), mvd_err=0.
- bins gt0=1,1; gt1=0,0; sign=0,1 -> 6 requests (last 2 with ep_mode=1), mvd_out=(+1,-1).
- EGK_ORDER=1, comp0 gt0=1, gt1=1, prefix 1,0, suffix 0,1, sign 1; comp1 gt0=0 -> abs_minus2=3, mvd_out=(-5,0).
- MAX_PREFIX=4, comp0 prefix 1,1,1,1 -> mvd_out_vld with mvd_err=1 and no 5th bypass request.
- dec_rdy held low 10 cycles after mvd_start -> no ctx_addr_vld. After release -> request next cycle, correct result.
- rst asserted during SUFFIX -> next cycle all outputs 0, no mvd_out_vld. A new mvd_start then decodes correctly.
